display_arbiter: RTL
====================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16'd50000, WAIT-state cycles before abort (used only with DISPLAY_ARB_TIMEOUT_EN).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  3  level requests from requesters 0..2; held high until matching ack.
REQ-005 Port: req_value  input  24  packed values; requester i owns bits [8i+7:8i].
REQ-006 Port: grant  output  3  one-hot owner of the display; all zero when idle.
REQ-007 Port: ack  output  3  one-cycle pulse on bit i when requester i's display sequence ends.
REQ-008 Port: disp_trigger  output  1  one-cycle start pulse to the seven-segment display controller.
REQ-009 Port: disp_value  output  8  latched value presented to the display controller.
REQ-010 Port: disp_done  input  1  completion pulse from the display controller.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: timeout_err  output  1  sticky flag, set when a sequence is aborted by timeout.

Function
REQ-013 FSM states: IDLE, LAUNCH, WAIT, ACK; Moore outputs only.
REQ-014 IDLE: if any req bit high, select one by round-robin, latch its req_value into disp_value, set grant, go LAUNCH; else stay.
REQ-015 Round-robin: search starts at rr_ptr, then rr_ptr+1, rr_ptr+2, modulo 3; rr_ptr resets to 0.
REQ-016 LAUNCH: disp_trigger=1 for exactly this one cycle; next state WAIT unconditionally.
REQ-017 WAIT: disp_done sampled high -> ACK; otherwise stay.
REQ-018 disp_done is ignored in IDLE, LAUNCH and ACK.
REQ-019 ACK: ack[granted]=1 for this one cycle; rr_ptr <= (granted+1) mod 3; grant cleared at exit; next state IDLE.
REQ-020 Latency: req seen in IDLE cycle k -> disp_trigger high in cycle k+1; disp_done in cycle m -> ack high in cycle m+1; IDLE in cycle m+2.
REQ-021 disp_value and grant stay constant from LAUNCH through ACK; req_value changes during that interval have no effect.
REQ-022 Granted requester dropping req mid-sequence: sequence still completes and ack is still issued.
REQ-023 Request dropped before it is granted: never served, no ack.
REQ-024 Simultaneous requests: one grant per sequence; others wait; no requester waits more than two complete sequences.
REQ-025 A new grant is never issued in the ACK cycle; at least one IDLE cycle separates sequences.
REQ-026 grant, ack and disp_trigger are never asserted with more than one bit or pulse active per cycle.

Reset
REQ-027 rst_n low asynchronously forces IDLE, rr_ptr=0, grant=0, ack=0, disp_trigger=0, disp_value=0, busy=0, timeout_err=0, timeout counter=0.
REQ-028 Reset mid-sequence aborts it with no ack; the requester keeps req high and is re-arbitrated after release.
REQ-029 First arbitration takes place in the first clock edge after rst_n deasserts.

Configuration
REQ-030 Macro DISPLAY_ARB_TIMEOUT_EN defined: counter clears on entry to WAIT and increments each WAIT cycle.
REQ-031 With DISPLAY_ARB_TIMEOUT_EN: reaching TIMEOUT_CYCLES without disp_done -> ACK (ack still pulses) and timeout_err set until reset.
REQ-032 With DISPLAY_ARB_TIMEOUT_EN: disp_done and timeout in the same cycle count as done; timeout_err is not set.
REQ-033 Macro absent: no counter logic is present, WAIT lasts until disp_done, and timeout_err is tied to 0.

Verification
REQ-034 req=3'b001, value0=8'd123, disp_done 5 cycles after trigger -> trigger in cycle k+1, disp_value=123, ack=3'b001 one cycle after done.
REQ-035 req=3'b111 held, values 10/20/30 -> grant order 0,1,2,0; disp_value sequence 10,20,30,10.
REQ-036 After ack to requester 1, req=3'b011 -> requester 0 granted before requester 1 (rr_ptr=2 then wraps to 0).
REQ-037 rst_n low in WAIT with req=3'b100 -> all outputs 0 immediately, no ack; after release, requester 2 granted with trigger on the 2nd edge.
REQ-038 DISPLAY_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, disp_done never asserted -> ack after 8 WAIT cycles, timeout_err=1 persistent; without macro -> busy stays high indefinitely.
REQ-039 req_value changed during WAIT and disp_done asserted in LAUNCH -> disp_value unchanged, the LAUNCH-cycle done is ignored, and the sequence ends only on a later done.

Source files
------------

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Shares one seven-segment display controller between three requesters.
// A round-robin pick is made in IDLE, the winner's byte is latched, the
// controller is started with a one-cycle trigger, and the requester is
// acknowledged once the controller reports completion.
//
// Handshake (one rule for the whole block):
//   req[i] is a level request held until ack[i] pulses; grant is one-hot and
//   stable from LAUNCH through ACK; disp_trigger is a one-cycle start pulse;
//   disp_done is a one-cycle completion pulse that only counts in WAIT.
//
// Optional feature: define DISPLAY_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without disp_done. The abort still acknowledges the
// requester and sets the sticky timeout_err flag.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req[2:0]     in   level requests
//   req_value    in   packed bytes, requester i owns [8i+7:8i]
//   grant[2:0]   out  one-hot current owner, zero when idle
//   ack[2:0]     out  one-cycle end-of-sequence pulse
//   disp_trigger out  one-cycle start pulse to the display controller
//   disp_value   out  latched byte for the display controller
//   disp_done    in   completion pulse from the display controller
//   busy         out  high whenever the FSM is not in IDLE
//   timeout_err  out  sticky abort flag (always 0 without the macro)
//   state_dbg    out  current FSM state for observation
// -----------------------------------------------------------------------------
module display_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] req_value,
  output logic [2:0]  grant,
  output logic [2:0]  ack,
  output logic        disp_trigger,
  output logic [7:0]  disp_value,
  input  logic        disp_done,
  output logic        busy,
  output logic        timeout_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  rr_ptr_q;
  logic [1:0]  gidx_q;
  logic [2:0]  grant_q;
  logic [7:0]  value_q;

  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic [2:0]  cand;
  logic        timeout_hit;

  // Round-robin pick: scan rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3), first hit wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!sel_valid && req[cand[1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[1:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sel_valid) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      // A done in the same cycle as the timeout takes the normal path;
      // timeout_hit already excludes that case.
      ST_WAIT:   if (disp_done || timeout_hit) state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 2'd0;
      gidx_q   <= 2'd0;
      grant_q  <= 3'd0;
      value_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && sel_valid) begin
        gidx_q  <= sel_idx;
        grant_q <= 3'b001 << sel_idx;
        value_q <= req_value[{sel_idx, 3'b000} +: 8];
      end
      if (state_q == ST_ACK) begin
        grant_q  <= 3'd0;
        rr_ptr_q <= (gidx_q == 2'd2) ? 2'd0 : gidx_q + 2'd1;
      end
    end
  end

`ifdef DISPLAY_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        terr_q;

  // cnt_q counts completed WAIT cycles; the abort fires at the end of the
  // TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout_hit = (state_q == ST_WAIT) && !disp_done &&
                       (({1'b0, wait_cnt_q} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 16'd0;
      terr_q     <= 1'b0;
    end else begin
      if (state_q == ST_LAUNCH) wait_cnt_q <= 16'd0;
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + 16'd1;
      if (timeout_hit) terr_q <= 1'b1;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_timeout_cfg;

  // The limit has no meaning without the counter.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // Moore outputs decoded from registered state only.
  assign grant        = grant_q;
  assign ack          = (state_q == ST_ACK) ? grant_q : 3'd0;
  assign disp_trigger = (state_q == ST_LAUNCH);
  assign disp_value   = value_q;
  assign busy         = (state_q != ST_IDLE);
  assign state_dbg    = state_q;

endmodule
